// File: rtl/core_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_pipe_ctrl_pkg
// Shared constants and types for the xRV32I pipeline sequencing controller.
//   - pipe_state_e : controller FSM encoding (2-bit).
//   - Hold/Flush enable constants for the pipeline register controls.
//   - Register-file and word constants shared with the rest of the core.
// -----------------------------------------------------------------------------
package core_pipe_ctrl_pkg;

   localparam int unsigned INST_REGBus = 32;
   localparam int unsigned RegAddrW    = 5;

   localparam logic [RegAddrW-1:0]    ZeroReg  = 5'd0;
   localparam logic [INST_REGBus-1:0] ZeroWord = 32'h0000_0000;

   localparam logic HoldEnable   = 1'b1;
   localparam logic HoldDisable  = 1'b0;
   localparam logic FlushEnable  = 1'b1;
   localparam logic FlushDisable = 1'b0;

   typedef enum logic [1:0] {
      PIPE_STATE_RUN    = 2'd0,
      PIPE_STATE_FLUSH  = 2'd1,
      PIPE_STATE_DRAIN  = 2'd2,
      PIPE_STATE_HALTED = 2'd3
   } pipe_state_e;

endpackage : core_pipe_ctrl_pkg

// File: rtl/core_hazard_detect.sv
// -----------------------------------------------------------------------------
// core_hazard_detect
// Combinational load-use compare between the instruction in ID and a load in EX.
// Ports:
//   id_rs1_in/id_rs2_in           : ID source register indices
//   id_rs1_used_in/id_rs2_used_in : ID instruction really reads that source
//   ex_is_load_in, ex_rd_in       : EX instruction is a load, and its rd
//   hazard_out                    : 1 when ID needs a value the load has not produced
// -----------------------------------------------------------------------------
module core_hazard_detect
   import core_pipe_ctrl_pkg::*;
(
   input  logic [RegAddrW-1:0] id_rs1_in,
   input  logic [RegAddrW-1:0] id_rs2_in,
   input  logic                id_rs1_used_in,
   input  logic                id_rs2_used_in,
   input  logic                ex_is_load_in,
   input  logic [RegAddrW-1:0] ex_rd_in,
   output logic                hazard_out
);

   logic rs1_match_s;
   logic rs2_match_s;

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign rs1_match_s = id_rs1_used_in && (id_rs1_in == ex_rd_in);
   assign rs2_match_s = id_rs2_used_in && (id_rs2_in == ex_rd_in);
   assign hazard_out  = ex_is_load_in && (ex_rd_in != ZeroReg) && (rs1_match_s || rs2_match_s);

endmodule : core_hazard_detect

// File: rtl/core_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// core_pipe_ctrl
// Pipeline sequencing controller for the xRV32I IF/ID/EX chain. Produces hold,
// flush and redirect controls for load-use stalls, taken jumps, data-memory
// freezes and external halt (drain then halt).
// Parameters:
//   FLUSH_CYCLES (1..7) : cycles the flush outputs stay high after a redirect
//   DRAIN_CYCLES (1..7) : bubble-insertion cycles before HALTED
// Ports:
//   clk, rst (async, active-low)
//   id_* / ex_* inputs  : hazard operands, jump request and target
//   mem_busy_in         : freeze the whole pipe
//   halt_req_in         : level halt request
//   *_hold_out, *_flush_out, jump_out, jump_addr_out : combinational controls
//   halt_ack_out        : registered, high while HALTED
//   stall_cnt_out, flush_cnt_out : perf counters, only with
//                                  CORE_PIPE_CTRL_PERF_CNT_EN defined
// -----------------------------------------------------------------------------
module core_pipe_ctrl
   import core_pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned DRAIN_CYCLES = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RegAddrW-1:0]    id_rs1_in,
   input  logic [RegAddrW-1:0]    id_rs2_in,
   input  logic                   id_rs1_used_in,
   input  logic                   id_rs2_used_in,
   input  logic                   ex_is_load_in,
   input  logic [RegAddrW-1:0]    ex_rd_in,
   input  logic                   ex_jump_req_in,
   input  logic [INST_REGBus-1:0] ex_jump_addr_in,
   input  logic                   mem_busy_in,
   input  logic                   halt_req_in,
   output logic                   pc_hold_out,
   output logic                   if_id_hold_out,
   output logic                   if_id_flush_out,
   output logic                   id_ex_hold_out,
   output logic                   id_ex_flush_out,
   output logic                   jump_out,
   output logic [INST_REGBus-1:0] jump_addr_out,
`ifdef CORE_PIPE_CTRL_PERF_CNT_EN
   output logic [31:0]            stall_cnt_out,
   output logic [31:0]            flush_cnt_out,
`endif
   output logic                   halt_ack_out
);

   localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 32'd1);
   localparam logic [2:0] DrainReload = 3'(DRAIN_CYCLES - 32'd1);
   localparam bit         MultiFlush  = (FLUSH_CYCLES > 32'd1);

   pipe_state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        halt_ack_q, halt_ack_d;
   logic        hazard_s;
   logic        pc_hold_s, if_id_hold_s, if_id_flush_s;
   logic        id_ex_hold_s, id_ex_flush_s, jump_s;

   core_hazard_detect u_hazard (
      .id_rs1_in      (id_rs1_in),
      .id_rs2_in      (id_rs2_in),
      .id_rs1_used_in (id_rs1_used_in),
      .id_rs2_used_in (id_rs2_used_in),
      .ex_is_load_in  (ex_is_load_in),
      .ex_rd_in       (ex_rd_in),
      .hazard_out     (hazard_s)
   );

   // Next-state and control decode; priority mem_busy > jump > load-use > halt.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_hold_s     = HoldDisable;
      if_id_hold_s  = HoldDisable;
      id_ex_hold_s  = HoldDisable;
      if_id_flush_s = FlushDisable;
      id_ex_flush_s = FlushDisable;
      jump_s        = 1'b0;
      if (mem_busy_in) begin
         // EX is frozen and will re-present any jump, so nothing else may act.
         pc_hold_s    = HoldEnable;
         if_id_hold_s = HoldEnable;
         id_ex_hold_s = HoldEnable;
      end else if (ex_jump_req_in) begin
         jump_s        = 1'b1;
         if_id_flush_s = FlushEnable;
         id_ex_flush_s = FlushEnable;
         case (state_q)
            PIPE_STATE_DRAIN, PIPE_STATE_HALTED: begin
               // A redirect while draining restarts the drain; without a
               // pending halt request the core simply resumes.
               if (halt_req_in) begin
                  state_d = state_q;
                  cnt_d   = DrainReload;
               end else begin
                  state_d = PIPE_STATE_RUN;
                  cnt_d   = 3'd0;
               end
            end
            default: begin
               if (MultiFlush) begin
                  state_d = PIPE_STATE_FLUSH;
                  cnt_d   = FlushReload;
               end else begin
                  state_d = PIPE_STATE_RUN;
                  cnt_d   = 3'd0;
               end
            end
         endcase
      end else begin
         case (state_q)
            PIPE_STATE_RUN: begin
               if (hazard_s) begin
                  pc_hold_s     = HoldEnable;
                  if_id_hold_s  = HoldEnable;
                  id_ex_flush_s = FlushEnable;
               end else if (halt_req_in) begin
                  state_d = PIPE_STATE_DRAIN;
                  cnt_d   = DrainReload;
               end else begin
                  state_d = PIPE_STATE_RUN;
               end
            end
            PIPE_STATE_FLUSH: begin
               if_id_flush_s = FlushEnable;
               id_ex_flush_s = FlushEnable;
               if (hazard_s) begin
                  pc_hold_s    = HoldEnable;
                  if_id_hold_s = HoldEnable;
               end else begin
                  pc_hold_s = HoldDisable;
               end
               if (cnt_q <= 3'd1) begin
                  state_d = PIPE_STATE_RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            PIPE_STATE_DRAIN: begin
               pc_hold_s     = HoldEnable;
               if_id_flush_s = FlushEnable;
               if (!halt_req_in) begin
                  state_d = PIPE_STATE_RUN;
                  cnt_d   = 3'd0;
               end else if (cnt_q == 3'd0) begin
                  state_d = PIPE_STATE_HALTED;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            PIPE_STATE_HALTED: begin
               pc_hold_s     = HoldEnable;
               if_id_flush_s = FlushEnable;
               id_ex_flush_s = FlushEnable;
               if (!halt_req_in) begin
                  state_d = PIPE_STATE_RUN;
               end else begin
                  state_d = PIPE_STATE_HALTED;
               end
            end
            default: begin
               state_d = PIPE_STATE_RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
      halt_ack_d = (state_d == PIPE_STATE_HALTED);
   end

   // FSM state, counter and registered halt acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= PIPE_STATE_RUN;
         cnt_q      <= 3'd0;
         halt_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         halt_ack_q <= halt_ack_d;
      end
   end

   // Controls are forced low while reset is asserted.
   assign pc_hold_out     = rst & pc_hold_s;
   assign if_id_hold_out  = rst & if_id_hold_s;
   assign if_id_flush_out = rst & if_id_flush_s;
   assign id_ex_hold_out  = rst & id_ex_hold_s;
   assign id_ex_flush_out = rst & id_ex_flush_s;
   assign jump_out        = rst & jump_s;
   assign jump_addr_out   = rst ? ex_jump_addr_in : ZeroWord;
   assign halt_ack_out    = halt_ack_q;

`ifdef CORE_PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Counters freeze with the pipe; halted cycles are not stalls.
   always_comb begin
      if (!mem_busy_in && pc_hold_s && (state_q != PIPE_STATE_HALTED)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (id_ex_flush_s) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers, wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_out = stall_cnt_q;
   assign flush_cnt_out = flush_cnt_q;
`endif

endmodule : core_pipe_ctrl

// File: doc/core_pipe_ctrl.md
# core_pipe_ctrl

Pipeline sequencing controller for the xRV32I core. It sits beside the IF / IF-ID / ID / ID-EX / EX chain and drives the hold, flush and redirect controls of that chain. It detects load-use hazards between the instruction in ID and a load in EX, and applies taken-jump/branch flushes. It also freezes the pipe while the data-memory port is busy, and drains and halts the core on an external halt request.

## Interface
Parameters:
- FLUSH_CYCLES, default 1: number of cycles the flush outputs stay high after a taken redirect (1..7).
- DRAIN_CYCLES, default 2: bubble-insertion cycles before HALTED is reached (1..7).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs1_in / id_rs2_in  in  5 each  source register indices of the instruction in ID.
- id_rs1_used_in / id_rs2_used_in  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_is_load_in  in  1  instruction in EX is a load (INST_TYPE_IL).
- ex_rd_in  in  5  destination register of the EX instruction.
- ex_jump_req_in  in  1  EX resolved a taken branch, JAL or JALR.
- ex_jump_addr_in  in  32  redirect target.
- mem_busy_in  in  1  data-memory port not ready this cycle.
- halt_req_in  in  1  external halt request, level.
- pc_hold_out  out  1  PC keeps its value.
- if_id_hold_out  out  1  IF/ID register keeps its value.
- if_id_flush_out  out  1  IF/ID loads a NOP.
- id_ex_hold_out  out  1  ID/EX register keeps its value.
- id_ex_flush_out  out  1  ID/EX loads a bubble, with reg_we and eval_en cleared.
- jump_out  out  1  PC loads jump_addr_out.
- jump_addr_out  out  32  redirect target.
- halt_ack_out  out  1  core is halted, registered.
- stall_cnt_out / flush_cnt_out  out  32 each  performance counters. Present only with the macro.

## Operation
- FSM states: RUN, FLUSH, DRAIN, HALTED. Reset state is RUN.
- Priority each cycle: mem_busy > jump > load-use > halt.
- mem_busy_in=1:
  - pc_hold, if_id_hold and id_ex_hold are all 1. Every other control output is 0.
  - The jump request is ignored this cycle, because EX is frozen and re-presents it.
  - FSM state and counters are frozen.
- Jump, when mem_busy_in=0 and ex_jump_req_in=1:
  - jump_out=1, jump_addr_out=ex_jump_addr_in, if_id_flush=1 and id_ex_flush=1, all in the same cycle.
  - If FLUSH_CYCLES>1, enter FLUSH with the counter set to FLUSH_CYCLES-1. FLUSH holds both flush outputs high until the counter reaches 0, then returns to RUN.
  - A jump in DRAIN restarts the drain count.
  - A jump in FLUSH reloads the flush counter.
- Load-use:
  - Condition: ex_is_load_in AND ex_rd_in≠0 AND ((id_rs1_used_in AND id_rs1_in==ex_rd_in) OR (id_rs2_used_in AND id_rs2_in==ex_rd_in)).
  - Response: pc_hold=1, if_id_hold=1, id_ex_flush=1, for exactly one cycle. The inserted bubble clears the condition.
  - Suppressed while in DRAIN or HALTED.
- Halt:
  - halt_req_in=1 in RUN moves to DRAIN. DRAIN asserts pc_hold and if_id_flush for DRAIN_CYCLES cycles, then moves to HALTED.
  - HALTED: pc_hold, if_id_flush and id_ex_flush are 1, and halt_ack_out=1.
  - halt_req_in=0 in HALTED returns to RUN next cycle with halt_ack_out=0. halt_req_in=0 during DRAIN aborts to RUN.
- jump_addr_out is always driven as ex_jump_addr_in; it only has meaning while jump_out=1.

## Timing
- All hold, flush and jump outputs are combinational from inputs and current state: zero-cycle latency.
- halt_ack_out is registered and rises DRAIN_CYCLES+1 cycles after halt_req_in is first sampled high, with no jumps or mem_busy in between.
- Reset (async assert, any state): state=RUN, counters cleared, halt_ack_out=0. While rst=0 all outputs are 0, including jump_addr_out=0.
- Release is synchronous to the next clk edge.

## Configuration
- Macro: CORE_PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt_out increments on every cycle with pc_hold_out=1 while not HALTED.
  - flush_cnt_out increments on every cycle with id_ex_flush_out=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent.

## Structure
- Additions to the shared defines.v:
  - FSM state encodings: PIPE_STATE_RUN/FLUSH/DRAIN/HALTED, 2-bit.
  - HoldEnable / HoldDisable and FlushEnable / FlushDisable constants.
- Reuse the existing ZeroReg, ZeroWord and INST_REGBus constants.
- One sub-module, core_hazard_detect: a combinational load-use compare producing a single hazard bit.

## Test plan
- Load-use hazard: lw x5 in EX, add x6,x5,x1 in ID with rs1_used=1 → one cycle of pc_hold=if_id_hold=id_ex_flush=1, then all 0.
- No hazard on x0: same as the load-use case but with ex_rd=0 → no stall.
- Jump with FLUSH_CYCLES=2: ex_jump_req=1, addr=0x0000_0100 → jump_out=1 with addr 0x100 and both flushes high for 2 cycles. A simultaneous load-use hazard is ignored.
- Memory freeze: mem_busy=1 for 3 cycles with jump_req=1 → all three holds high, jump_out=0. In the cycle mem_busy drops, jump_out=1.
- Halt with DRAIN_CYCLES=2: halt_req rises → halt_ack=1 on the 3rd edge. halt_req falls → ack=0 and pc_hold=0 the next cycle.
- Reset mid-FLUSH: rst low → outputs 0 immediately. After release the FSM is in RUN and the perf counters read 0 (macro defined).
